// File: rtl/cam_capture_rgb332.sv
// cam_capture_rgb332: OV7670-style camera capture front end.
// Oversamples the camera interface in the clk domain, packs each RGB565 byte
// pair into an RGB332 pixel and writes it to a linear IMG_W x IMG_H frame buffer.
//
// Ports:
//   clk, rst_n      system clock (>= 4x CAM_pclk), async active-low reset
//   CAM_pclk        camera pixel clock, sampled as data
//   CAM_vsync       frame sync, high = vertical blank
//   CAM_href        line valid, high = bytes valid
//   CAM_px_data     camera byte
//   px_addr         frame-buffer write address, row*IMG_W + col
//   px_data         RGB332 pixel {R[2:0],G[2:0],B[1:0]}
//   px_wr           one-clk write strobe per pixel
//   frame_done      one-clk pulse at the end of a complete frame
//   ovf_err         sticky: excess bytes/lines dropped, cleared on vsync rise
//
// Build option: define CAM_TESTPAT_EN to replace pixel data with 8 vertical
// colour bars (camera bytes ignored; timing and addressing unchanged).

module cam_capture_rgb332 #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] px_addr,
    output logic [7:0]    px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          ovf_err
);

    localparam int unsigned COL_W = $clog2(IMG_W + 1);
    localparam int unsigned ROW_W = $clog2(IMG_H + 1);

    typedef enum logic [0:0] {ST_IDLE, ST_FRAME} state_t;

    // Input synchronisers; pclk gets a third stage for edge detection
    logic       pclk_s1, pclk_s2, pclk_s3;
    logic       vs_s1, vs_s2;
    logic       href_s1, href_s2;
    logic [7:0] data_s1, data_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s1 <= 1'b0;
            pclk_s2 <= 1'b0;
            pclk_s3 <= 1'b0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            href_s1 <= 1'b0;
            href_s2 <= 1'b0;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            pclk_s1 <= CAM_pclk;
            pclk_s2 <= pclk_s1;
            pclk_s3 <= pclk_s2;
            vs_s1   <= CAM_vsync;
            vs_s2   <= vs_s1;
            href_s1 <= CAM_href;
            href_s2 <= href_s1;
            data_s1 <= CAM_px_data;
            data_s2 <= data_s1;
        end
    end

    // Capture state
    state_t           state, state_nxt;
    logic             href_q, href_q_nxt;     // href at previous pclk rise
    logic             vs_q, vs_q_nxt;         // vsync at previous pclk rise
    logic             byte_ph, byte_ph_nxt;
    logic [5:0]       byte1, byte1_nxt;       // only the bits kept in RGB332
    logic [ROW_W-1:0] row, row_nxt;
    logic [COL_W-1:0] col, col_nxt;
    logic [AW-1:0]    line_base, line_base_nxt;
    logic             line_wr, line_wr_nxt;   // a pixel was written on this line
    logic [AW-1:0]    px_addr_nxt;
    logic [7:0]       px_data_nxt;
    logic             px_wr_nxt, frame_done_nxt, ovf_err_nxt;

    logic pclk_rise, vs_rise, vs_fall, href_fall, line_start, byte_en;
    logic row_full, col_full;
    logic [7:0] pixel;

    assign pclk_rise  = pclk_s2 & ~pclk_s3;
    assign vs_rise    = pclk_rise &  vs_s2 & ~vs_q;
    assign vs_fall    = pclk_rise & ~vs_s2 &  vs_q;
    assign href_fall  = pclk_rise &  href_q & ~href_s2;
    assign line_start = pclk_rise &  href_s2 & ~href_q;
    assign byte_en    = pclk_rise &  href_s2;
    assign row_full   = (row == ROW_W'(IMG_H));
    assign col_full   = (col == COL_W'(IMG_W));

`ifdef CAM_TESTPAT_EN
    // Vertical colour bars: bar index bits select full-scale R, G, B
    logic [2:0] bar;
    assign bar   = 3'(col / COL_W'(IMG_W / 8));
    assign pixel = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
`else
    assign pixel = {byte1, data_s2[4:3]};
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            href_q     <= 1'b0;
            vs_q       <= 1'b0;
            byte_ph    <= 1'b0;
            byte1      <= 6'h00;
            row        <= '0;
            col        <= '0;
            line_base  <= '0;
            line_wr    <= 1'b0;
            px_addr    <= '0;
            px_data    <= 8'h00;
            px_wr      <= 1'b0;
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            href_q     <= href_q_nxt;
            vs_q       <= vs_q_nxt;
            byte_ph    <= byte_ph_nxt;
            byte1      <= byte1_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            line_base  <= line_base_nxt;
            line_wr    <= line_wr_nxt;
            px_addr    <= px_addr_nxt;
            px_data    <= px_data_nxt;
            px_wr      <= px_wr_nxt;
            frame_done <= frame_done_nxt;
            ovf_err    <= ovf_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt      = state;
        href_q_nxt     = href_q;
        vs_q_nxt       = vs_q;
        byte_ph_nxt    = byte_ph;
        byte1_nxt      = byte1;
        row_nxt        = row;
        col_nxt        = col;
        line_base_nxt  = line_base;
        line_wr_nxt    = line_wr;
        px_addr_nxt    = px_addr;
        px_data_nxt    = px_data;
        px_wr_nxt      = 1'b0;
        frame_done_nxt = 1'b0;
        ovf_err_nxt    = ovf_err;

        if (pclk_rise) begin
            href_q_nxt = href_s2;
            vs_q_nxt   = vs_s2;
        end
        if (vs_rise) begin
            ovf_err_nxt = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (vs_fall) begin
                    state_nxt     = ST_FRAME;
                    row_nxt       = '0;
                    col_nxt       = '0;
                    byte_ph_nxt   = 1'b0;
                    line_base_nxt = '0;
                    line_wr_nxt   = 1'b0;
                end
            end
            ST_FRAME: begin
                if (vs_rise) begin
                    // Frame end or abort; only a full frame reports done
                    state_nxt      = ST_IDLE;
                    frame_done_nxt = row_full;
                end else if (href_fall) begin
                    // Dangling odd byte is discarded; empty lines do not advance
                    byte_ph_nxt = 1'b0;
                    if (line_wr) begin
                        row_nxt       = row + ROW_W'(1);
                        col_nxt       = '0;
                        line_base_nxt = line_base + AW'(IMG_W);
                        line_wr_nxt   = 1'b0;
                    end
                end else if (byte_en) begin
                    if (row_full) begin
                        if (line_start) begin
                            ovf_err_nxt = 1'b1;
                        end
                    end else if (!byte_ph) begin
                        byte1_nxt   = {data_s2[7:5], data_s2[2:0]};
                        byte_ph_nxt = 1'b1;
                    end else begin
                        byte_ph_nxt = 1'b0;
                        if (col_full) begin
                            ovf_err_nxt = 1'b1;
                        end else begin
                            px_wr_nxt   = 1'b1;
                            px_addr_nxt = line_base + AW'(col);
                            px_data_nxt = pixel;
                            col_nxt     = col + COL_W'(1);
                            line_wr_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Directed bench for cam_capture_rgb332 on a reduced 32x8 frame.
module tb_cam_capture_rgb332;

    localparam int unsigned W  = 32;
    localparam int unsigned H  = 8;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          CAM_pclk = 1'b0;
    logic          CAM_vsync = 1'b1;
    logic          CAM_href = 1'b0;
    logic [7:0]    CAM_px_data = 8'h00;
    logic [AW-1:0] px_addr;
    logic [7:0]    px_data;
    logic          px_wr;
    logic          frame_done;
    logic          ovf_err;

    int     n_vec = 0;
    int     n_err = 0;
    int     n_wr = 0;
    int     n_done = 0;
    longint cyc = 0;
    longint last_wr_cyc = 0;
    int     w0, d0;

    logic [AW-1:0] exp_addr_q[$];
    logic [7:0]    exp_data_q[$];
    logic [7:0]    bar_lut [8] = '{8'h00, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};

    // Byte pairs and their hand-packed RGB332 values
    logic [7:0]    pb1 [4] = '{8'hE0, 8'h1F, 8'hA5, 8'h12};
    logic [7:0]    pb2 [4] = '{8'h00, 8'h18, 8'h5A, 8'h08};
    logic [7:0]    pex [4] = '{8'hE0, 8'h1F, 8'hB7, 8'h09};

    always #5 clk = ~clk;

    cam_capture_rgb332 #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .px_addr     (px_addr),
        .px_data     (px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .ovf_err     (ovf_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One camera byte: data changes while pclk is low, pclk 25 MHz
    task automatic pclk_cycle(input logic [7:0] d, input logic h);
        CAM_px_data = d;
        CAM_href    = h;
        #20 CAM_pclk = 1'b1;
        #20 CAM_pclk = 1'b0;
    endtask

    task automatic blank(input int n);
        repeat (n) pclk_cycle(8'h00, 1'b0);
    endtask

    task automatic send_bytes(input int nbytes, input logic [7:0] b1, input logic [7:0] b2);
        for (int i = 0; i < nbytes; i++) pclk_cycle(((i % 2) == 1) ? b2 : b1, 1'b1);
    endtask

    task automatic expect_line(input int row, input int npx, input logic [7:0] px);
        for (int k = 0; k < npx; k++) begin
            if (row < H && k < W) begin
                exp_addr_q.push_back(AW'(row * W + k));
`ifdef CAM_TESTPAT_EN
                exp_data_q.push_back(bar_lut[k / (W / 8)]);
`else
                exp_data_q.push_back(px);
`endif
            end
        end
    endtask

    task automatic send_line(input int row, input int nbytes, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] px);
        expect_line(row, nbytes / 2, px);
        send_bytes(nbytes, b1, b2);
        blank(4);
    endtask

    task automatic frame_start();
        CAM_vsync = 1'b1;
        blank(8);
        CAM_vsync = 1'b0;
        blank(8);
    endtask

    task automatic frame_end();
        CAM_vsync = 1'b1;
        blank(8);
    endtask

    // Write scoreboard and frame_done rules
    always @(negedge clk) begin
        cyc++;
        if (px_wr) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_data_q.size() == 0) begin
                check("unexpected_wr_addr", 32'(px_addr), 32'hFFFF_FFFF);
            end else begin
                check("px_addr", 32'(px_addr), 32'(exp_addr_q.pop_front()));
                check("px_data", 32'(px_data), 32'(exp_data_q.pop_front()));
            end
        end
        if (frame_done) begin
            n_done++;
            check("done_excl_wr", 32'(px_wr), 32'd0);
            check("done_gap_ok", 32'((cyc - last_wr_cyc) >= 4), 32'd1);
        end
    end

    initial begin
        // Reset state
        #17;
        check("rst_px_addr", 32'(px_addr), 32'd0);
        check("rst_px_data", 32'(px_data), 32'd0);
        check("rst_px_wr", 32'(px_wr), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_ovf_err", 32'(ovf_err), 32'd0);
        #5 rst_n = 1'b1;

        // Nominal frame, all 0xE0 pixels
        w0 = n_wr; d0 = n_done;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, 2 * W, 8'hE0, 8'h00, 8'hE0);
        check("nom_ovf_in_frame", 32'(ovf_err), 32'd0);
        frame_end();
        check("nom_writes", 32'(n_wr - w0), 32'(W * H));
        check("nom_done", 32'(n_done - d0), 32'd1);
        check("nom_last_addr", 32'(px_addr), 32'(W * H - 1));
        check("nom_ovf", 32'(ovf_err), 32'd0);

        // Full frame with varied byte pairs
        w0 = n_wr; d0 = n_done;
        frame_start();
        for (int r = 0; r < H; r++) send_line(r, 2 * W, pb1[r % 4], pb2[r % 4], pex[r % 4]);
        frame_end();
        check("var_writes", 32'(n_wr - w0), 32'(W * H));
        check("var_done", 32'(n_done - d0), 32'd1);

        // Long lines and extra lines
        w0 = n_wr; d0 = n_done;
        frame_start();
        send_line(0, 2 * W + 4, 8'hA5, 8'h5A, 8'hB7);
        check("long_ovf_set", 32'(ovf_err), 32'd1);
        for (int r = 1; r < H + 2; r++) send_line(r, 2 * W + 4, 8'hA5, 8'h5A, 8'hB7);
        check("long_ovf_held", 32'(ovf_err), 32'd1);
        check("long_last_addr", 32'(px_addr), 32'(W * H - 1));
        frame_end();
        check("long_ovf_cleared", 32'(ovf_err), 32'd0);
        check("long_writes", 32'(n_wr - w0), 32'(W * H));
        check("long_done", 32'(n_done - d0), 32'd1);

        // Short odd line then a normal line; short frame gives no done
        w0 = n_wr; d0 = n_done;
        frame_start();
        send_line(0, 41, 8'h12, 8'h08, 8'h09);
        check("short_addr_end", 32'(px_addr), 32'd19);
        send_line(1, 2 * W, 8'h1F, 8'h18, 8'h1F);
        frame_end();
        check("short_writes", 32'(n_wr - w0), 32'(20 + W));
        check("short_done", 32'(n_done - d0), 32'd0);
        check("short_ovf", 32'(ovf_err), 32'd0);

        // vsync rises mid-line
        w0 = n_wr; d0 = n_done;
        frame_start();
        for (int r = 0; r < 3; r++) send_line(r, 2 * W, 8'hE0, 8'h00, 8'hE0);
        expect_line(3, 10, 8'hE0);
        send_bytes(21, 8'hE0, 8'h00);
        CAM_vsync = 1'b1;
        send_bytes(6, 8'hE0, 8'h00);
        blank(8);
        check("abort_writes", 32'(n_wr - w0), 32'(3 * W + 10));
        check("abort_done", 32'(n_done - d0), 32'd0);
        w0 = n_wr;
        frame_start();
        send_line(0, 2 * W, 8'hA5, 8'h5A, 8'hB7);
        send_line(1, 2 * W, 8'hA5, 8'h5A, 8'hB7);
        frame_end();
        check("abort_restart_writes", 32'(n_wr - w0), 32'(2 * W));
        check("abort_restart_done", 32'(n_done - d0), 32'd0);

        // Reset mid-frame during line 2
        w0 = n_wr; d0 = n_done;
        frame_start();
        send_line(0, 2 * W, 8'hE0, 8'h00, 8'hE0);
        send_line(1, 2 * W, 8'hE0, 8'h00, 8'hE0);
        expect_line(2, 5, 8'hE0);
        send_bytes(10, 8'hE0, 8'h00);
        blank(1);
        check("pre_rst_addr", 32'(px_addr), 32'(2 * W + 4));
        rst_n = 1'b0;
        #1;
        check("mid_rst_px_addr", 32'(px_addr), 32'd0);
        check("mid_rst_px_data", 32'(px_data), 32'd0);
        check("mid_rst_px_wr", 32'(px_wr), 32'd0);
        #29 rst_n = 1'b1;
        send_bytes(54, 8'hE0, 8'h00);
        blank(4);
        send_bytes(2 * W, 8'hE0, 8'h00);
        blank(4);
        frame_end();
        check("rst_writes", 32'(n_wr - w0), 32'(2 * W + 5));
        check("rst_done", 32'(n_done - d0), 32'd0);
        w0 = n_wr;
        frame_start();
        send_line(0, 2 * W, 8'h12, 8'h08, 8'h09);
        check("rst_restart_addr", 32'(px_addr), 32'(W - 1));
        send_line(1, 2 * W, 8'h12, 8'h08, 8'h09);
        frame_end();
        check("rst_restart_writes", 32'(n_wr - w0), 32'(2 * W));

        #200;
        check("exp_queue_drained", 32'(exp_data_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
